// File: rtl/pipe_addsub_lanes.sv
// Multi-lane registered add/sub pipeline with valid/ready backpressure and saturating modes.
// Optional sticky carry/borrow status is enabled by defining PIPE_ADDSUB_STICKY_EN.
module pipe_addsub_lanes #(
  parameter int W      = 20,
  parameter int LANES  = 2,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [LANES*W-1:0]   a,
  input  logic [LANES*W-1:0]   b,
  output logic [LANES*W-1:0]   y,
  output logic [LANES-1:0]     cflag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES-1:0]     sticky_ovf,
  input  logic                 sticky_clr
);

  localparam int DW = LANES * W;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [DW-1:0]     dat_q [STAGES];
  logic [DW-1:0]     dat_d [STAGES];
  logic [LANES-1:0]  car_q [STAGES];
  logic [LANES-1:0]  car_d [STAGES];
  logic [DW-1:0]     s1_y;
  logic [LANES-1:0]  s1_c;
  logic [W:0]        sum;
  logic [W:0]        diff;
  logic              stall;

  // The whole pipeline freezes as one unit when the output beat is refused.
  assign stall     = vld_q[STAGES-1] && !out_ready;
  assign in_ready  = !stall;
  assign y         = dat_q[STAGES-1];
  assign cflag     = car_q[STAGES-1];
  assign out_valid = vld_q[STAGES-1];

  always_comb begin : lane_alu
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    s1_y = '0;
    s1_c = '0;
    sum  = '0;
    diff = '0;
    for (int i = 0; i < LANES; i++) begin
      sum  = {1'b0, a[i*W +: W]} + {1'b0, b[i*W +: W]};
      diff = {1'b0, a[i*W +: W]} - {1'b0, b[i*W +: W]};
      case (op)
        2'b00: begin s1_y[i*W +: W] = sum[W-1:0];  s1_c[i] = sum[W];  end
        2'b01: begin s1_y[i*W +: W] = diff[W-1:0]; s1_c[i] = diff[W]; end
        2'b10: begin
          s1_y[i*W +: W] = sum[W] ? {W{1'b1}} : sum[W-1:0];
          s1_c[i]        = sum[W];
        end
        default: begin
          s1_y[i*W +: W] = diff[W] ? {W{1'b0}} : diff[W-1:0];
          s1_c[i]        = diff[W];
        end
      endcase
    end
  end

  // Data only moves with a valid beat, so y/cflag hold across idle cycles.
  always_comb begin : stage_next
    vld_d = vld_q;
    dat_d = dat_q;
    car_d = car_q;
    if (!stall) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        dat_d[0] = s1_y;
        car_d[0] = s1_c;
      end
      for (int s = 1; s < STAGES; s++) begin
        vld_d[s] = vld_q[s-1];
        if (vld_q[s-1]) begin
          dat_d[s] = dat_q[s-1];
          car_d[s] = car_q[s-1];
        end
      end
    end
  end

  // NOTE: data registers are reset as well as valids, so y/cflag read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        dat_q[s] <= '0;
        car_q[s] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      car_q <= car_d;
    end
  end

`ifdef PIPE_ADDSUB_STICKY_EN
  logic [LANES-1:0] sticky_q, sticky_d;

  // A transfer setting a lane overrides a clear in the same cycle.
  always_comb begin
    sticky_d = sticky_clr ? '0 : sticky_q;
    if (out_valid && out_ready) sticky_d = sticky_d | cflag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_ovf = sticky_q;
`else
  logic sticky_clr_unused;
  assign sticky_clr_unused = sticky_clr;
  assign sticky_ovf        = '0;
`endif

endmodule

// File: tb/tb_pipe_addsub_lanes.sv
// Directed self-checking bench for pipe_addsub_lanes (W=8, LANES=2; STAGES 2, 1 and 4).
module tb_pipe_addsub_lanes;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic        out_ready;
  logic        sticky_clr;

  logic        in_ready, out_valid;
  logic [15:0] y;
  logic [1:0]  cflag, sticky_ovf;
  logic        in_ready1, out_valid1;
  logic [15:0] y1;
  logic [1:0]  cflag1, sticky1;
  logic        in_ready4, out_valid4;
  logic [15:0] y4;
  logic [1:0]  cflag4, sticky4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_addsub_lanes #(.W(8), .LANES(2), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .y(y), .cflag(cflag), .out_valid(out_valid), .out_ready(out_ready),
    .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr));

  pipe_addsub_lanes #(.W(8), .LANES(2), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .op(op),
    .a(a), .b(b), .y(y1), .cflag(cflag1), .out_valid(out_valid1), .out_ready(out_ready),
    .sticky_ovf(sticky1), .sticky_clr(sticky_clr));

  pipe_addsub_lanes #(.W(8), .LANES(2), .STAGES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .op(op),
    .a(a), .b(b), .y(y4), .cflag(cflag4), .out_valid(out_valid4), .out_ready(out_ready),
    .sticky_ovf(sticky4), .sticky_clr(sticky_clr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat on the STAGES=2 instance with out_ready held high.
  task automatic beat(input string tag, input logic [1:0] o, input logic [15:0] aa,
                      input logic [15:0] bb, input logic [15:0] ey, input logic [1:0] ec);
    op = o; a = aa; b = bb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_y"}, 32'(y), 32'(ey));
    check({tag, "_c"}, 32'(cflag), 32'(ec));
  endtask

  task automatic chk_sweep(input string tag, input int s, input int cyc, input logic ov,
                           input logic [15:0] yy, input logic [1:0] cc);
    int k;
    k = cyc - s;
    check({tag, "_valid"}, 32'(ov), 32'(k >= 0 && k < 6));
    if (k >= 0 && k < 6) begin
      check({tag, "_y"}, 32'(yy), 32'({8'(k + 255), 8'(k + 16)}));
      check({tag, "_c"}, 32'(cc), 32'((k >= 1) ? 2'b10 : 2'b00));
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] exp_q[$];
    logic [1:0]  expc_q[$];
    logic [8:0]  s0, s1;
    logic [15:0] ey;
    logic [1:0]  ec;
    int sent, recv, cyc;

    rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; a = '0; b = '0;
    out_ready = 1'b1; sticky_clr = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_cflag", 32'(cflag), 32'd0);
    check("rst_sticky", 32'(sticky_ovf), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Lane0 0xF0+0x20 wraps to 0x10 with carry; lane1 0x01+0x02 = 0x03.
    beat("add_wrap", 2'b00, 16'h01F0, 16'h0220, 16'h0310, 2'b01);
    tick();
    check("hold_valid", 32'(out_valid), 32'd0);
    check("hold_y", 32'(y), 32'h0310);
    check("hold_c", 32'(cflag), 32'h1);

    beat("sat_add", 2'b10, 16'h01F0, 16'h0220, 16'h03FF, 2'b01);
    beat("sat_sub", 2'b11, 16'h0510, 16'h0905, 16'h000B, 2'b10);
    beat("sub_wrap", 2'b01, 16'h0510, 16'h0905, 16'hFC0B, 2'b10);
    beat("sat_sub_edge", 2'b11, 16'hFF07, 16'h0007, 16'hFF00, 2'b00);
    tick();

    // Sticky status: clear, set by a lane0 borrow, persist, clear, set beats clear.
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("sticky_cleared0", 32'(sticky_ovf), 32'd0);
    beat("borrow", 2'b01, 16'h0501, 16'h0102, 16'h04FF, 2'b01);
    tick();
    tick();
    tick();
`ifdef PIPE_ADDSUB_STICKY_EN
    check("sticky_set", 32'(sticky_ovf), 32'h1);
`else
    check("sticky_off", 32'(sticky_ovf), 32'h0);
`endif
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("sticky_clr", 32'(sticky_ovf), 32'h0);
    beat("borrow2", 2'b01, 16'h0501, 16'h0102, 16'h04FF, 2'b01);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
`ifdef PIPE_ADDSUB_STICKY_EN
    check("sticky_set_wins", 32'(sticky_ovf), 32'h1);
`else
    check("sticky_off2", 32'(sticky_ovf), 32'h0);
`endif

    // Backpressure: six beats, out_ready low during cycles 3..5.
    sent = 0; recv = 0; cyc = 0;
    op = 2'b00;
    while (recv < 6 && cyc < 40) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 6);
      a = {8'(sent), 8'(sent * 64)};
      b = 16'hFE50;
      #3;
      check("bp_in_ready", 32'(in_ready), 32'(!(cyc >= 3 && cyc <= 5)));
      check("bp_out_valid", 32'(out_valid), 32'(cyc >= 2 && cyc <= 10));
      if (in_valid && in_ready) begin
        s0 = {1'b0, 8'(sent * 64)} + 9'h050;
        s1 = {1'b0, 8'(sent)} + 9'h0FE;
        exp_q.push_back({s1[7:0], s0[7:0]});
        expc_q.push_back({s1[8], s0[8]});
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("bp_extra_beat", 32'd1, 32'd0);
        end else begin
          ey = exp_q.pop_front();
          ec = expc_q.pop_front();
          check("bp_y", 32'(y), 32'(ey));
          check("bp_c", 32'(cflag), 32'(ec));
        end
        recv++;
      end
      cyc++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_sent", 32'(sent), 32'd6);
    check("bp_recv", 32'(recv), 32'd6);
    check("bp_cycles", 32'(cyc), 32'd11);
    check("bp_drained", 32'(out_valid), 32'd0);

    // Reset mid-stream with three beats issued.
    op = 2'b00;
    for (int i = 0; i < 3; i++) begin
      a = {8'(i + 1), 8'h11}; b = 16'h0101; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_y", 32'(y), 32'd0);
    check("mid_rst_c", 32'(cflag), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_empty", 32'(out_valid), 32'd0);
    beat("post_rst", 2'b00, 16'h1234, 16'h0101, 16'h1335, 2'b00);
    for (int i = 0; i < 6; i++) tick();

    // Latency sweep across the three depths with continuous beats.
    op = 2'b00;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 6);
      a = {8'hFF, 8'(c)};
      b = {8'(c), 8'h10};
      #1;
      chk_sweep("lat1", 1, c, out_valid1, y1, cflag1);
      chk_sweep("lat2", 2, c, out_valid, y, cflag);
      chk_sweep("lat4", 4, c, out_valid4, y4, cflag4);
      tick();
    end
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
